// File: rtl/hls_deadlock_report_unit.sv
// Deadlock report unit: filters HLS monitor `block` outputs for persistence, latches the
// first offender with a cycle stamp, and presents one report over a valid/ready handshake.
module hls_deadlock_report_unit #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = 1024,
  parameter int CNT_W   = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [NUM_MON-1:0] rpt_mask,
  output logic [31:0]        rpt_stamp,
  output logic               deadlock
);

  typedef enum logic [1:0] {
    WATCH  = 2'd0,
    REPORT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // A counter at CNT_MAX with its block still high on the next edge is the trip condition.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q [NUM_MON];
  logic [CNT_W-1:0]     cnt_d [NUM_MON];
  logic [31:0]          stamp_q, stamp_d;
  logic                 rpt_valid_q, rpt_valid_d;
  logic [IDX_W-1:0]     rpt_idx_q, rpt_idx_d;
  logic [NUM_MON-1:0]   rpt_mask_q, rpt_mask_d;
  logic [31:0]          rpt_stamp_q, rpt_stamp_d;
  logic                 deadlock_q, deadlock_d;

  logic [NUM_MON-1:0]   hit;
  logic [IDX_W-1:0]     trip_idx;

  always_comb begin
    hit      = '0;
    trip_idx = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      hit[i] = enable && mon_block[i] && (cnt_q[i] == CNT_MAX);
    end
    // Scan from the top so the lowest tripping index is the one left standing.
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (hit[i]) trip_idx = IDX_W'(i);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stamp_d     = stamp_q + 32'd1;
    rpt_valid_d = rpt_valid_q;
    rpt_idx_d   = rpt_idx_q;
    rpt_mask_d  = rpt_mask_q;
    rpt_stamp_d = rpt_stamp_q;
    deadlock_d  = deadlock_q;

    if (clear) begin
      state_d     = WATCH;
      rpt_valid_d = 1'b0;
      deadlock_d  = 1'b0;
      for (int i = 0; i < NUM_MON; i++) cnt_d[i] = '0;
    end else begin
      unique case (state_q)
        WATCH: begin
          for (int i = 0; i < NUM_MON; i++) begin
            if (enable && mon_block[i]) begin
              cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
            end else begin
              cnt_d[i] = '0;
            end
          end
          if (|hit) begin
            state_d     = REPORT;
            rpt_valid_d = 1'b1;
            deadlock_d  = 1'b1;
            rpt_idx_d   = trip_idx;
            rpt_mask_d  = hit;
            rpt_stamp_d = stamp_q;
          end
        end
        REPORT: begin
          if (rpt_valid_q && rpt_ready) begin
            state_d     = HOLD;
            rpt_valid_d = 1'b0;
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = WATCH;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= WATCH;
      stamp_q     <= '0;
      rpt_valid_q <= 1'b0;
      rpt_idx_q   <= '0;
      rpt_mask_q  <= '0;
      rpt_stamp_q <= '0;
      deadlock_q  <= 1'b0;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      stamp_q     <= stamp_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_idx_q   <= rpt_idx_d;
      rpt_mask_q  <= rpt_mask_d;
      rpt_stamp_q <= rpt_stamp_d;
      deadlock_q  <= deadlock_d;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_idx   = rpt_idx_q;
  assign rpt_mask  = rpt_mask_q;
  assign rpt_stamp = rpt_stamp_q;
  assign deadlock  = deadlock_q;

endmodule

// File: tb/tb_hls_deadlock_report_unit.sv
// Bench for hls_deadlock_report_unit: directed phase table with end-of-phase expectations,
// plus a per-cycle scoreboard fed by an independent run-length model.
module tb_hls_deadlock_report_unit;

  localparam int NUM_MON = 4;
  localparam int IDX_W   = 2;
  localparam int THRESH  = 8;
  localparam int CNT_W   = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic [NUM_MON-1:0] mon_block = '0;
  logic               clear = 1'b0;
  logic               rpt_ready = 1'b0;
  logic               rpt_valid;
  logic [IDX_W-1:0]   rpt_idx;
  logic [NUM_MON-1:0] rpt_mask;
  logic [31:0]        rpt_stamp;
  logic               deadlock;

  always #5 clock = ~clock;

  hls_deadlock_report_unit #(
    .NUM_MON(NUM_MON), .IDX_W(IDX_W), .THRESH(THRESH), .CNT_W(CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mon_block (mon_block),
    .clear     (clear),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_idx   (rpt_idx),
    .rpt_mask  (rpt_mask),
    .rpt_stamp (rpt_stamp),
    .deadlock  (deadlock)
  );

  typedef struct packed {
    logic        valid;
    logic        dl;
    logic [1:0]  idx;
    logic [3:0]  mask;
    logic [31:0] stamp;
  } out_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       rdy;
    logic [3:0] blk;
    int         n;
    out_t       exp;
  } vec_t;

  typedef enum int {M_WATCH, M_REPORT, M_HOLD} mstate_t;

  vec_t    vecs[$];
  out_t    sb_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  mstate_t     mst = M_WATCH;
  out_t        m   = '0;
  int          run[NUM_MON] = '{default: 0};
  logic [31:0] m_ctr = '0;

  function automatic out_t get_act();
    out_t a;
    a.valid = rpt_valid;
    a.dl    = deadlock;
    a.idx   = rpt_idx;
    a.mask  = rpt_mask;
    a.stamp = rpt_stamp;
    return a;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b deadlock=%b idx=%0d mask=%b stamp=%0d, want valid=%b deadlock=%b idx=%0d mask=%b stamp=%0d",
               name, act.valid, act.dl, act.idx, act.mask, act.stamp,
               exp.valid, exp.dl, exp.idx, exp.mask, exp.stamp);
    end
  endtask

  // Run-length model: a monitor trips once it has THRESH consecutive enabled highs in WATCH.
  task automatic model_step();
    logic [31:0] cur;
    logic [3:0]  tmask;
    int          first;
    if (!reset) begin
      mst   = M_WATCH;
      m     = '0;
      m_ctr = '0;
      for (int i = 0; i < NUM_MON; i++) run[i] = 0;
    end else begin
      cur   = m_ctr;
      m_ctr = m_ctr + 1;
      if (clear) begin
        mst     = M_WATCH;
        m.valid = 1'b0;
        m.dl    = 1'b0;
        for (int i = 0; i < NUM_MON; i++) run[i] = 0;
      end else if (mst == M_WATCH) begin
        tmask = '0;
        first = -1;
        for (int i = 0; i < NUM_MON; i++) begin
          run[i] = (enable && mon_block[i]) ? run[i] + 1 : 0;
          if (run[i] >= THRESH) begin
            tmask[i] = 1'b1;
            if (first < 0) first = i;
          end
        end
        if (tmask != 0) begin
          mst     = M_REPORT;
          m.valid = 1'b1;
          m.dl    = 1'b1;
          m.idx   = 2'(first);
          m.mask  = tmask;
          m.stamp = cur;
        end
      end else if (mst == M_REPORT && rpt_ready) begin
        mst     = M_HOLD;
        m.valid = 1'b0;
      end
    end
    sb_q.push_back(m);
  endtask

  task automatic step();
    out_t exp;
    model_step();
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, got valid=%b want an entry", rpt_valid);
    end else begin
      exp = sb_q.pop_front();
      check("scoreboard", get_act(), exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic e, input logic c,
                     input logic rd, input logic [3:0] b, input int n,
                     input logic v, input logic d, input logic [1:0] ix,
                     input logic [3:0] mk, input logic [31:0] st);
    vec_t t;
    t.name = nm; t.rst_n = r; t.en = e; t.clr = c; t.rdy = rd; t.blk = b; t.n = n;
    t.exp.valid = v; t.exp.dl = d; t.exp.idx = ix; t.exp.mask = mk; t.exp.stamp = st;
    vecs.push_back(t);
  endtask

  initial begin
    //   name         rst en clr rdy blk      n    vld dl idx mask     stamp
    add("reset",      0, 1, 0, 0, 4'b0000,   3,   0, 0, 0, 4'b0000,   0);
    add("idle100",    1, 1, 0, 0, 4'b0000, 100,   0, 0, 0, 4'b0000,   0);
    add("reset2",     0, 1, 0, 0, 4'b0000,   1,   0, 0, 0, 4'b0000,   0);
    add("idle10",     1, 1, 0, 0, 4'b0000,  10,   0, 0, 0, 4'b0000,   0);
    add("b2_7",       1, 1, 0, 0, 4'b0100,   7,   0, 0, 0, 4'b0000,   0);
    add("b2_trip",    1, 1, 0, 0, 4'b0100,   1,   1, 1, 2, 4'b0100,  17);
    add("b2_hs",      1, 1, 0, 1, 4'b0000,   1,   0, 1, 2, 4'b0100,  17);
    add("clr1",       1, 1, 1, 0, 4'b0000,   1,   0, 0, 2, 4'b0100,  17);
    add("b13_7",      1, 1, 0, 0, 4'b1010,   7,   0, 0, 2, 4'b0100,  17);
    add("b13_trip",   1, 1, 0, 0, 4'b1010,   1,   1, 1, 1, 4'b1010,  27);
    add("wait20",     1, 0, 0, 0, 4'b1111,  20,   1, 1, 1, 4'b1010,  27);
    add("b13_hs",     1, 1, 0, 1, 4'b1111,   1,   0, 1, 1, 4'b1010,  27);
    add("hold_ign",   1, 1, 0, 0, 4'b1111,  10,   0, 1, 1, 4'b1010,  27);
    add("clr2",       1, 1, 1, 0, 4'b0000,   1,   0, 0, 1, 4'b1010,  27);
    add("glitch_a",   1, 1, 0, 0, 4'b0001,   7,   0, 0, 1, 4'b1010,  27);
    add("glitch_lo",  1, 1, 0, 0, 4'b0000,   1,   0, 0, 1, 4'b1010,  27);
    add("glitch_b",   1, 1, 0, 0, 4'b0001,   7,   0, 0, 1, 4'b1010,  27);
    add("gap",        1, 1, 0, 0, 4'b0000,   1,   0, 0, 1, 4'b1010,  27);
    add("en_a",       1, 1, 0, 0, 4'b0001,   4,   0, 0, 1, 4'b1010,  27);
    add("en_lo",      1, 0, 0, 0, 4'b0001,   1,   0, 0, 1, 4'b1010,  27);
    add("en_b",       1, 1, 0, 0, 4'b0001,   7,   0, 0, 1, 4'b1010,  27);
    add("en_trip",    1, 1, 0, 0, 4'b0001,   1,   1, 1, 0, 4'b0001,  88);
    add("clr_rdy",    1, 1, 1, 1, 4'b0000,   1,   0, 0, 0, 4'b0001,  88);
    add("fresh_7",    1, 1, 0, 0, 4'b1000,   7,   0, 0, 0, 4'b0001,  88);
    add("fresh_trip", 1, 1, 0, 0, 4'b1000,   1,   1, 1, 3, 4'b1000,  97);
    add("clr3",       1, 1, 1, 0, 4'b0000,   1,   0, 0, 3, 4'b1000,  97);
    add("ct_7",       1, 1, 0, 0, 4'b0100,   7,   0, 0, 3, 4'b1000,  97);
    add("clr_trip",   1, 1, 1, 0, 4'b0100,   1,   0, 0, 3, 4'b1000,  97);
    add("ct_after7",  1, 1, 0, 0, 4'b0100,   7,   0, 0, 3, 4'b1000,  97);
    add("ct_trip",    1, 1, 0, 0, 4'b0100,   1,   1, 1, 2, 4'b0100, 114);
    add("rst_rep",    0, 1, 0, 0, 4'b0100,   1,   0, 0, 0, 4'b0000,   0);
    add("pr_7",       1, 1, 0, 0, 4'b0010,   7,   0, 0, 0, 4'b0000,   0);
    add("pr_trip",    1, 1, 0, 0, 4'b0010,   1,   1, 1, 1, 4'b0010,   7);
    add("pr_hs",      1, 1, 0, 1, 4'b0000,   1,   0, 1, 1, 4'b0010,   7);
    add("clr4",       1, 1, 1, 0, 4'b0000,   1,   0, 0, 1, 4'b0010,   7);
    add("stag_a",     1, 1, 0, 0, 4'b0001,   1,   0, 0, 1, 4'b0010,   7);
    add("stag_b",     1, 1, 0, 0, 4'b0011,   6,   0, 0, 1, 4'b0010,   7);
    add("stag_trip",  1, 1, 0, 0, 4'b0011,   1,   1, 1, 0, 4'b0001,  17);

    foreach (vecs[k]) begin
      reset     = vecs[k].rst_n;
      enable    = vecs[k].en;
      clear     = vecs[k].clr;
      rpt_ready = vecs[k].rdy;
      mon_block = vecs[k].blk;
      for (int c = 0; c < vecs[k].n; c++) step();
      check(vecs[k].name, get_act(), vecs[k].exp);
    end

    // Reset while parked in HOLD: the sticky flag and report fields must all clear.
    reset = 1'b1; enable = 1'b1; clear = 1'b0; rpt_ready = 1'b1; mon_block = 4'b0000;
    step();
    check("stag_hs", get_act(), out_t'({1'b0, 1'b1, 2'd0, 4'b0001, 32'd17}));
    reset = 1'b0; rpt_ready = 1'b0; mon_block = 4'b1111;
    step();
    check("rst_hold", get_act(), out_t'({1'b0, 1'b0, 2'd0, 4'b0000, 32'd0}));
    reset = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("post_rst", get_act(), out_t'({1'b0, 1'b0, 2'd0, 4'b0000, 32'd0}));

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
